check_zero: RTL and testbench
=============================

# check_zero

Registered 64-bit add-and-flag stage for the pipelined CPU's ALU. It adds two 64-bit operands through a ripple chain of one-bit full adders. It derives the ARM condition flags N, Z, V and C, with zero detection as its central function, and presents the sum and flags from registers one cycle later. It sits in the execute stage, feeding the flag register and branch logic.

## Interface
- WIDTH, default 64: operand and result width; must be ≥ 2.
- clk  input  1: rising-edge clock.
- reset  input  1: asynchronous, active-high reset.
- in_valid  input  1: operands valid this cycle.
- A  input  WIDTH: operand A.
- B  input  WIDTH: operand B.
- out_valid  output  1: registered copy of in_valid.
- result  output  WIDTH: registered A + B, modulo 2^WIDTH.
- negative  output  1: result[WIDTH-1].
- zero  output  1: 1 when every result bit is 0.
- overflow  output  1: signed overflow, carry into MSB XOR carry out of MSB.
- carry_out  output  1: carry out of the MSB.

One clock; reset is asynchronous and active-high.

## Operation
- Bit 0 carry-in is 0.
- Bit i ≥ 1 carry-in is the carry-out of bit i-1. The MSB must take the carry out of bit WIDTH-2; it must not take an earlier bit's carry.
- fa1_bit function: sum = a ^ b ^ cin; cout = (a & b) | (a & cin) | (b & cin).
- Zero: NOR of all result bits, built as a balanced OR-reduction tree, then inverted.
- Flags are computed from the unregistered sum and captured together with it.
- When in_valid = 0, result and flags hold their previous values and out_valid goes 0.

## Timing
- Latency is 1 cycle: operands sampled on edge k appear on the outputs after edge k; there is no throughput stall.
- On reset assertion, immediately and independent of clk: result = 0, out_valid = 0, negative = 0, overflow = 0, carry_out = 0, zero = 1 (consistent with result = 0).
- Reset deasserted mid-stream: the first capture occurs on the first rising edge with reset low.
- The combinational path is the full ripple plus the zero tree; it must close within one clock period.

## Configuration
- CHECK_ZERO_SUB_EN defined:
  - adds input sub (1 bit).
  - When sub = 1, B is inverted into the chain and the bit 0 carry-in is 1, so result = A − B.
  - carry_out = 1 means no borrow; overflow uses the same XOR rule.
- CHECK_ZERO_SUB_EN undefined: no sub port; add only.

## Structure
- Shared package alu_pkg:
  - WIDTH default constant;
  - flag struct type {negative, zero, overflow, carry_out};
  - reset flag constant (zero = 1, others 0).
- Sub-module fa1_bit: ports a, b, cin, sum, cout; purely combinational, instantiated WIDTH times in a generate loop.
- Zero reduction tree and output registers live in check_zero.

## Test plan
- A = 0x10, B = 0x1 → after one edge result = 0x11; zero = 0, negative = 0, overflow = 0, carry_out = 0; out_valid = 1.
- A = 0xFFFF_FFFF_FFFF_FFFF, B = 0x1 → result = 0; zero = 1, carry_out = 1, overflow = 0, negative = 0.
- A = 0x7FFF_FFFF_FFFF_FFFF, B = 0x1 → result = 0x8000_0000_0000_0000; negative = 1, overflow = 1, carry_out = 0, zero = 0.
- A = 0x8000_0000_0000_0000, B = 0x8000_0000_0000_0000 → result = 0; zero = 1, overflow = 1, carry_out = 1.
- Assert reset between edges while outputs are nonzero → outputs immediately become result = 0, zero = 1, other flags 0, out_valid = 0. The next valid operands after deassertion appear one edge later.
- With CHECK_ZERO_SUB_EN defined: sub = 1, A = 5, B = 5 → result = 0, zero = 1, carry_out = 1. Then A = 3, B = 5 → result = 0xFFFF_FFFF_FFFF_FFFE, negative = 1, carry_out = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the condition-flag bundle.
package alu_pkg;

  localparam int WIDTH_DEF = 64;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic carry_out;
  } flags_t;

  // Flags matching a cleared result register.
  localparam flags_t FLAGS_RST = '{negative: 1'b0, zero: 1'b1, overflow: 1'b0, carry_out: 1'b0};

endpackage

// File: rtl/fa1_bit.sv
// One-bit full adder, the ripple-chain cell.
// Latency: combinational. Backpressure: none.
// Pure combinational cell; no state.
module fa1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/check_zero.sv
// Registered ripple add with N/Z/V/C flags; CHECK_ZERO_SUB_EN adds a subtract input.
// Latency: 1 cycle. Backpressure: none, accepts a new operand pair every cycle.
// in_valid low holds result/flags and clears out_valid.
module check_zero
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef CHECK_ZERO_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW     = 1 << LEVELS;

  logic [WIDTH-1:0] b_eff;
  logic             carry_in0;
  logic [WIDTH-1:0] sum;
  logic             msb_cin;
  logic             msb_cout;
  flags_t           flags_nxt;
  flags_t           flags_q;

`ifdef CHECK_ZERO_SUB_EN
  // Two's-complement subtract: invert B and inject a carry at bit 0.
  assign b_eff     = B ^ {WIDTH{sub}};
  assign carry_in0 = sub;
`else
  assign b_eff     = B;
  assign carry_in0 = 1'b0;
`endif

  // Each stage owns its carry signals so the chain is a string of distinct nets.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = carry_in0;
    end else begin : g_next
      assign ci = g_stage[i-1].co;
    end
    fa1_bit u_fa (
      .a    (A[i]),
      .b    (b_eff[i]),
      .cin  (ci),
      .sum  (sum[i]),
      .cout (co)
    );
  end

  assign msb_cin  = g_stage[WIDTH-1].ci;
  assign msb_cout = g_stage[WIDTH-1].co;

  // Balanced OR tree; leaves beyond WIDTH are padded with 0.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [(PW >> l)-1:0] node;
    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < PW; j++) begin : g_bit
        if (j < WIDTH) begin : g_use
          assign node[j] = sum[j];
        end else begin : g_pad
          assign node[j] = 1'b0;
        end
      end
    end else begin : g_or
      for (genvar k = 0; k < (PW >> l); k++) begin : g_pair
        assign node[k] = g_lvl[l-1].node[2*k] | g_lvl[l-1].node[2*k+1];
      end
    end
  end

  always_comb begin
    flags_nxt           = FLAGS_RST;
    flags_nxt.negative  = sum[WIDTH-1];
    flags_nxt.zero      = ~g_lvl[LEVELS].node[0];
    flags_nxt.overflow  = msb_cin ^ msb_cout;
    flags_nxt.carry_out = msb_cout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= FLAGS_RST;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result  <= sum;
        flags_q <= flags_nxt;
      end
    end
  end

  assign negative  = flags_q.negative;
  assign zero      = flags_q.zero;
  assign overflow  = flags_q.overflow;
  assign carry_out = flags_q.carry_out;

endmodule

// File: tb/tb_check_zero.sv
// Directed-vector bench for check_zero with hand-computed sums and flags.
module tb_check_zero;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] A;
  logic [63:0] B;
`ifdef CHECK_ZERO_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;

  int n_cmp = 0;
  int n_err = 0;

  check_zero #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
`ifdef CHECK_ZERO_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Compare every output against an expected set.
  task automatic chk_all(input string tag, input logic [63:0] res, input logic vld,
                         input logic n, input logic z, input logic v, input logic c);
    chk({tag, ".result"},    result,    res);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, vld});
    chk({tag, ".negative"},  {63'd0, negative},  {63'd0, n});
    chk({tag, ".zero"},      {63'd0, zero},      {63'd0, z});
    chk({tag, ".overflow"},  {63'd0, overflow},  {63'd0, v});
    chk({tag, ".carry_out"}, {63'd0, carry_out}, {63'd0, c});
  endtask

  // Drive one operand pair away from the edge, then sample just after the capturing edge.
  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic s);
    @(negedge clk);
    A        = a;
    B        = b;
    in_valid = 1'b1;
`ifdef CHECK_ZERO_SUB_EN
    sub      = s;
`endif
    if (s) begin end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
`ifdef CHECK_ZERO_SUB_EN
    sub      = 1'b0;
`endif
    #2;
    chk_all("rst", 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    apply(64'h10, 64'h1, 1'b0);
    chk_all("add_small", 64'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk_all("wrap", 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk_all("pos_ovf", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    chk_all("neg_ovf", 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Carry into the MSB comes only from bit 62.
    apply(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0);
    chk_all("msb_cin", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk_all("neg_sum", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    apply(64'h0, 64'h1, 1'b0);
    chk_all("lsb_only", 64'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    apply(64'h0, 64'h0, 1'b0);
    chk_all("zero_in", 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    apply(64'h1234_0000_0000_0000, 64'h0000_0000_0000_5678, 1'b0);
    chk_all("mixed", 64'h1234_0000_0000_5678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Idle cycle: outputs hold, out_valid drops.
    @(negedge clk);
    in_valid = 1'b0;
    A        = 64'hDEAD_BEEF_0000_0001;
    B        = 64'h1;
    @(posedge clk);
    #1;
    chk_all("hold", 64'h1234_0000_0000_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges while outputs are nonzero.
    apply(64'h8000_0000_0000_0010, 64'h1, 1'b0);
    chk_all("pre_rst", 64'h8000_0000_0000_0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(64'h20, 64'h3, 1'b0);
    chk_all("post_rst", 64'h23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef CHECK_ZERO_SUB_EN
    apply(64'h5, 64'h5, 1'b1);
    chk_all("sub_eq", 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(64'h3, 64'h5, 1'b1);
    chk_all("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(64'h8000_0000_0000_0000, 64'h1, 1'b1);
    chk_all("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`endif

    @(negedge clk);
    in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
